// File: rtl/decode_pkg.sv
// decode_pkg: control-bundle layout, ALU/data-size encodings and the DLX opcode decoder
package decode_pkg;

    localparam int CTRL_W          = 19;
    localparam int CTRL_PCTOREG    = 18;
    localparam int CTRL_REGTOPC    = 17;
    localparam int CTRL_JUMP       = 16;
    localparam int CTRL_BRANCH     = 15;
    localparam int CTRL_BRANCHZERO = 14;
    localparam int CTRL_RTYPE      = 13;
    localparam int CTRL_REGWRITE   = 12;
    localparam int CTRL_MEMTOREG   = 11;
    localparam int CTRL_MEMWRITE   = 10;
    localparam int CTRL_LOADSIGN   = 9;
    localparam int CTRL_MUL        = 8;
    localparam int CTRL_EXTOP      = 7;
    localparam int CTRL_LHIOP      = 6;
    localparam int CTRL_DSIZE_LO   = 4;
    localparam int CTRL_ALU_LO     = 0;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_SEQ, ALU_SNE, ALU_SLT, ALU_SGT, ALU_SLE, ALU_SGE
    } alu_op_e;

    typedef enum logic [1:0] {DS_BYTE, DS_HALF, DS_WORD} dsize_e;

    // First member is the MSB, so the struct matches the CTRL_* indices above.
    typedef struct packed {
        logic    pc_to_reg;
        logic    reg_to_pc;
        logic    jump;
        logic    branch;
        logic    branch_zero;
        logic    rtype;
        logic    reg_write;
        logic    mem_to_reg;
        logic    mem_write;
        logic    load_sign;
        logic    mul;
        logic    ext_op;
        logic    lhi_op;
        dsize_e  dsize;
        alu_op_e alu;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    // Unknown opcodes/functs decode to the bubble so they can never write state.
    function automatic ctrl_t decode_ctrl(input logic [5:0] op, input logic [5:0] fn);
        ctrl_t c;
        c = BUBBLE;
        case (op)
            6'h00: begin
                c.rtype = 1'b1;
                c.reg_write = 1'b1;
                case (fn)
                    6'h04: c.alu = ALU_SLL;
                    6'h06: c.alu = ALU_SRL;
                    6'h07: c.alu = ALU_SRA;
                    6'h20, 6'h21: c.alu = ALU_ADD;
                    6'h22, 6'h23: c.alu = ALU_SUB;
                    6'h24: c.alu = ALU_AND;
                    6'h25: c.alu = ALU_OR;
                    6'h26: c.alu = ALU_XOR;
                    6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2D: c.alu = alu_op_e'({1'b1, fn[2:0]});
                    default: c = BUBBLE;
                endcase
            end
            6'h01: if (fn == 6'h0E) begin c.rtype = 1'b1; c.reg_write = 1'b1; c.mul = 1'b1; end
            6'h02: c.jump = 1'b1;
            6'h03: begin c.jump = 1'b1; c.pc_to_reg = 1'b1; c.reg_write = 1'b1; end
            6'h04, 6'h05: begin c.branch = 1'b1; c.branch_zero = ~op[0]; c.ext_op = 1'b1; end
            6'h08: begin c.reg_write = 1'b1; c.ext_op = 1'b1; c.alu = ALU_ADD; end
            6'h09: begin c.reg_write = 1'b1; c.alu = ALU_ADD; end
            6'h0A: begin c.reg_write = 1'b1; c.ext_op = 1'b1; c.alu = ALU_SUB; end
            6'h0B: begin c.reg_write = 1'b1; c.alu = ALU_SUB; end
            6'h0C: begin c.reg_write = 1'b1; c.alu = ALU_AND; end
            6'h0D: begin c.reg_write = 1'b1; c.alu = ALU_OR; end
            6'h0E: begin c.reg_write = 1'b1; c.alu = ALU_XOR; end
            6'h0F: begin c.reg_write = 1'b1; c.lhi_op = 1'b1; c.alu = ALU_SLL; end
            6'h12: begin c.jump = 1'b1; c.reg_to_pc = 1'b1; end
            6'h13: begin c.jump = 1'b1; c.reg_to_pc = 1'b1; c.pc_to_reg = 1'b1; c.reg_write = 1'b1; end
            6'h14: begin c.reg_write = 1'b1; c.alu = ALU_SLL; end
            6'h16: begin c.reg_write = 1'b1; c.alu = ALU_SRL; end
            6'h17: begin c.reg_write = 1'b1; c.alu = ALU_SRA; end
            6'h18, 6'h19, 6'h1A, 6'h1B, 6'h1C, 6'h1D: begin
                c.reg_write = 1'b1;
                c.ext_op = 1'b1;
                c.alu = alu_op_e'({1'b1, op[2:0]});
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                c.reg_write = 1'b1;
                c.mem_to_reg = 1'b1;
                c.ext_op = 1'b1;
                c.load_sign = ~op[2];
                c.dsize = (op[1:0] == 2'b11) ? DS_WORD : (op[0] ? DS_HALF : DS_BYTE);
            end
            6'h28, 6'h29, 6'h2B: begin
                c.mem_write = 1'b1;
                c.ext_op = 1'b1;
                c.dsize = (op[1:0] == 2'b11) ? DS_WORD : (op[0] ? DS_HALF : DS_BYTE);
            end
            default: c = BUBBLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_pipelined_hazard.sv
// decode_hazard_unit: load-use hazard detection and the stall request back to IF/ID
//   reset    : active-low reset, forces stall low
//   valid    : ID holds a real instruction
//   flush    : ID instruction is being killed
//   ex_stall : EX cannot accept
//   ex_valid, ex_load, ex_dest : the instruction currently in EX
//   rs1, rs2 : ID source registers; uses_rs2 marks instructions that actually read rs2
//   hazard   : ID must wait one cycle for the load in EX
//   stall    : freeze PC and IF/ID
module decode_hazard_unit #(
    parameter int RADDR_W = 5
) (
    input  logic               reset,
    input  logic               valid,
    input  logic               flush,
    input  logic               ex_stall,
    input  logic               ex_valid,
    input  logic               ex_load,
    input  logic [RADDR_W-1:0] ex_dest,
    input  logic [RADDR_W-1:0] rs1,
    input  logic [RADDR_W-1:0] rs2,
    input  logic               uses_rs2,
    output logic               hazard,
    output logic               stall
);
    assign hazard = valid & ex_valid & ex_load & (ex_dest != '0) &
                    ((ex_dest == rs1) | ((ex_dest == rs2) & uses_rs2));
    assign stall  = reset & valid & (ex_stall | hazard) & ~flush;
endmodule

// File: rtl/decode_stage_pipelined.sv
// decode_stage_pipelined: DLX decode with ID/EX register, load-use bubble, EX-stall hold and flush
//   inputs : IF/ID slot (valid_in, nextPC_in, instruction_in), register-file reads (busA_in, busB_in),
//            flush_in, ex_stall_in and the EX-stage load info (ex_valid_in, ex_MemToReg_in, ex_destReg_in)
//   outputs: stall_out (combinational) and the registered ID/EX slot (valid_out, ctrl_out, nextPC_out,
//            busA_out, busB_out, storeData_out, imm16_out, imm26_out, destReg_out)
//   DECODE_WB_BYPASS_EN adds wb_RegWrite_in/wb_destReg_in/wb_data_in to forward the write-back value
module decode_stage_pipelined
    import decode_pkg::*;
#(
    parameter int SIZE      = 32,
    parameter int RADDR_W   = 5,
    parameter int LINK_REG  = 31,
    parameter int LHI_SHIFT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    input  logic [SIZE-1:0]    nextPC_in,
    input  logic [31:0]        instruction_in,
    input  logic [SIZE-1:0]    busA_in,
    input  logic [SIZE-1:0]    busB_in,
    input  logic               flush_in,
    input  logic               ex_stall_in,
    input  logic               ex_valid_in,
    input  logic               ex_MemToReg_in,
    input  logic [RADDR_W-1:0] ex_destReg_in,
`ifdef DECODE_WB_BYPASS_EN
    input  logic               wb_RegWrite_in,
    input  logic [RADDR_W-1:0] wb_destReg_in,
    input  logic [SIZE-1:0]    wb_data_in,
`endif
    output logic               stall_out,
    output logic               valid_out,
    output logic [CTRL_W-1:0]  ctrl_out,
    output logic [SIZE-1:0]    nextPC_out,
    output logic [SIZE-1:0]    busA_out,
    output logic [SIZE-1:0]    busB_out,
    output logic [SIZE-1:0]    storeData_out,
    output logic [15:0]        imm16_out,
    output logic [25:0]        imm26_out,
    output logic [RADDR_W-1:0] destReg_out
);
    logic [RADDR_W-1:0] rs1, rs2, rd, rw;
    logic [SIZE-1:0]    a_src, b_src, imm_zx, imm_sx, op_a, op_b;
    ctrl_t              dec, ctrl_d;
    logic               hazard;

    assign rs1    = RADDR_W'(instruction_in[25:21]);
    assign rs2    = RADDR_W'(instruction_in[20:16]);
    assign rd     = RADDR_W'(instruction_in[15:11]);
    assign imm_zx = {{(SIZE-16){1'b0}}, instruction_in[15:0]};
    assign imm_sx = {{(SIZE-16){instruction_in[15]}}, instruction_in[15:0]};

`ifdef DECODE_WB_BYPASS_EN
    assign a_src = (wb_RegWrite_in && wb_destReg_in != '0 && wb_destReg_in == rs1) ? wb_data_in : busA_in;
    assign b_src = (wb_RegWrite_in && wb_destReg_in != '0 && wb_destReg_in == rs2) ? wb_data_in : busB_in;
`else
    assign a_src = busA_in;
    assign b_src = busB_in;
`endif

    always_comb begin
        dec = decode_ctrl(instruction_in[31:26], instruction_in[5:0]);
        rw = dec.pc_to_reg ? RADDR_W'(LINK_REG) : (dec.rtype ? rd : rs2);
        ctrl_d = dec;
        ctrl_d.reg_write = dec.reg_write & (rw != '0);
        op_a = dec.lhi_op ? imm_zx : a_src;
        op_b = dec.rtype ? b_src : (dec.lhi_op ? SIZE'(LHI_SHIFT) : (dec.ext_op ? imm_sx : imm_zx));
    end

    decode_hazard_unit #(.RADDR_W(RADDR_W)) u_hazard (
        .reset    (reset),
        .valid    (valid_in),
        .flush    (flush_in),
        .ex_stall (ex_stall_in),
        .ex_valid (ex_valid_in),
        .ex_load  (ex_MemToReg_in),
        .ex_dest  (ex_destReg_in),
        .rs1      (rs1),
        .rs2      (rs2),
        .uses_rs2 (dec.rtype | dec.mem_write | dec.branch),
        .hazard   (hazard),
        .stall    (stall_out)
    );

    // Data fields of a bubble are don't-care, so they follow the slot whenever it is not held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out     <= 1'b0;
            ctrl_out      <= BUBBLE;
            nextPC_out    <= '0;
            busA_out      <= '0;
            busB_out      <= '0;
            storeData_out <= '0;
            imm16_out     <= '0;
            imm26_out     <= '0;
            destReg_out   <= '0;
        end else begin
            if (flush_in || !ex_stall_in) begin
                nextPC_out    <= nextPC_in;
                busA_out      <= op_a;
                busB_out      <= op_b;
                storeData_out <= b_src;
                imm16_out     <= instruction_in[15:0];
                imm26_out     <= instruction_in[25:0];
                destReg_out   <= rw;
            end
            if (flush_in || (!ex_stall_in && (hazard || !valid_in))) begin
                valid_out <= 1'b0;
                ctrl_out  <= BUBBLE;
            end else if (!ex_stall_in) begin
                valid_out <= 1'b1;
                ctrl_out  <= ctrl_d;
            end
        end
    end
endmodule

// File: tb/tb_decode_stage_pipelined.sv
// tb_decode_stage_pipelined: directed self-checking bench for decode_stage_pipelined
module tb_decode_stage_pipelined;
    logic        clk, reset, valid_in, flush_in, ex_stall_in, ex_valid_in, ex_MemToReg_in;
    logic [31:0] nextPC_in, instruction_in, busA_in, busB_in;
    logic [4:0]  ex_destReg_in;
    logic        stall_out, valid_out;
    logic [18:0] ctrl_out;
    logic [31:0] nextPC_out, busA_out, busB_out, storeData_out;
    logic [15:0] imm16_out;
    logic [25:0] imm26_out;
    logic [4:0]  destReg_out;
`ifdef DECODE_WB_BYPASS_EN
    logic        wb_RegWrite_in;
    logic [4:0]  wb_destReg_in;
    logic [31:0] wb_data_in;
`endif
    int tests = 0;
    int fails = 0;

    decode_stage_pipelined dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .nextPC_in(nextPC_in),
        .instruction_in(instruction_in), .busA_in(busA_in), .busB_in(busB_in),
        .flush_in(flush_in), .ex_stall_in(ex_stall_in), .ex_valid_in(ex_valid_in),
        .ex_MemToReg_in(ex_MemToReg_in), .ex_destReg_in(ex_destReg_in),
`ifdef DECODE_WB_BYPASS_EN
        .wb_RegWrite_in(wb_RegWrite_in), .wb_destReg_in(wb_destReg_in), .wb_data_in(wb_data_in),
`endif
        .stall_out(stall_out), .valid_out(valid_out), .ctrl_out(ctrl_out),
        .nextPC_out(nextPC_out), .busA_out(busA_out), .busB_out(busB_out),
        .storeData_out(storeData_out), .imm16_out(imm16_out), .imm26_out(imm26_out),
        .destReg_out(destReg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s1, input logic [4:0] s2, input logic [15:0] imm);
        return {op, s1, s2, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d, input logic [5:0] fn);
        return {6'h00, s1, s2, d, 5'h00, fn};
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
        @(negedge clk);
        valid_in = 1'b1;
        instruction_in = ins;
        busA_in = a;
        busB_in = b;
        nextPC_in = pc;
    endtask

    task automatic edge_settle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2 reset = 1'b0;
        valid_in = 1'b1;
        ex_stall_in = 1'b1;
        #1;
        tests++; if (stall_out !== 1'b0) begin fails++; $display("FAIL reset_stall got %0h want 0", stall_out); end
        edge_settle();
        edge_settle();
        tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid got %0h want 0", valid_out); end
        tests++; if (ctrl_out !== 19'h0) begin fails++; $display("FAIL reset_ctrl got %0h want 0", ctrl_out); end
        tests++; if (busA_out !== 32'h0 || busB_out !== 32'h0 || destReg_out !== 5'h0) begin
            fails++; $display("FAIL reset_data got %0h %0h %0h want 0 0 0", busA_out, busB_out, destReg_out); end
        @(negedge clk);
        reset = 1'b1;
        ex_stall_in = 1'b0;
        valid_in = 1'b0;
    endtask

    task automatic test_addi;
        drive(enc_i(6'h08, 5'd1, 5'd3, 16'hFFFF), 32'h10, 32'h55, 32'h104);
        #1;
        tests++; if (stall_out !== 1'b0) begin fails++; $display("FAIL addi_stall got %0h want 0", stall_out); end
        edge_settle();
        tests++; if (valid_out !== 1'b1) begin fails++; $display("FAIL addi_valid got %0h want 1", valid_out); end
        tests++; if (busB_out !== 32'hFFFFFFFF) begin fails++; $display("FAIL addi_busB got %0h want ffffffff", busB_out); end
        tests++; if (destReg_out !== 5'd3) begin fails++; $display("FAIL addi_dest got %0d want 3", destReg_out); end
        tests++; if (busA_out !== 32'h10) begin fails++; $display("FAIL addi_busA got %0h want 10", busA_out); end
        tests++; if (ctrl_out !== 19'h01080) begin fails++; $display("FAIL addi_ctrl got %0h want 1080", ctrl_out); end
        tests++; if (nextPC_out !== 32'h104 || storeData_out !== 32'h55) begin
            fails++; $display("FAIL addi_pc_store got %0h %0h want 104 55", nextPC_out, storeData_out); end
        tests++; if (imm16_out !== 16'hFFFF || imm26_out !== 26'h023FFFF) begin
            fails++; $display("FAIL addi_imm got %0h %0h want ffff 23ffff", imm16_out, imm26_out); end
    endtask

    task automatic test_operands;
        drive(enc_i(6'h0F, 5'd0, 5'd2, 16'hABCD), 32'h77, 32'h0, 32'h108);
        edge_settle();
        tests++; if (busA_out !== 32'h0000ABCD || busB_out !== 32'd16) begin
            fails++; $display("FAIL lhi_ops got %0h %0h want abcd 10", busA_out, busB_out); end
        tests++; if (ctrl_out !== 19'h01045 || destReg_out !== 5'd2) begin
            fails++; $display("FAIL lhi_ctrl got %0h %0d want 1045 2", ctrl_out, destReg_out); end
        drive(enc_i(6'h0C, 5'd1, 5'd1, 16'h8000), 32'h5, 32'h0, 32'h10C);
        edge_settle();
        tests++; if (busB_out !== 32'h00008000 || ctrl_out !== 19'h01002) begin
            fails++; $display("FAIL andi_zext got %0h %0h want 8000 1002", busB_out, ctrl_out); end
        drive(enc_i(6'h2B, 5'd2, 5'd9, 16'h0008), 32'h100, 32'hDEADBEEF, 32'h110);
        edge_settle();
        tests++; if (busA_out !== 32'h100 || busB_out !== 32'h8) begin
            fails++; $display("FAIL sw_ops got %0h %0h want 100 8", busA_out, busB_out); end
        tests++; if (storeData_out !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_data got %0h want deadbeef", storeData_out); end
        tests++; if (ctrl_out !== 19'h004A0 || destReg_out !== 5'd9) begin
            fails++; $display("FAIL sw_ctrl got %0h %0d want 4a0 9", ctrl_out, destReg_out); end
    endtask

    task automatic test_load_use;
        drive(enc_r(5'd5, 5'd2, 5'd7, 6'h20), 32'h11, 32'h22, 32'h200);
        ex_valid_in = 1'b1;
        ex_MemToReg_in = 1'b1;
        ex_destReg_in = 5'd5;
        #1;
        tests++; if (stall_out !== 1'b1) begin fails++; $display("FAIL lu_stall got %0h want 1", stall_out); end
        edge_settle();
        tests++; if (valid_out !== 1'b0 || ctrl_out !== 19'h0) begin
            fails++; $display("FAIL lu_bubble got %0h %0h want 0 0", valid_out, ctrl_out); end
        @(negedge clk);
        ex_valid_in = 1'b0;
        #1;
        tests++; if (stall_out !== 1'b0) begin fails++; $display("FAIL lu_release got %0h want 0", stall_out); end
        edge_settle();
        tests++; if (valid_out !== 1'b1 || destReg_out !== 5'd7 || ctrl_out !== 19'h03000) begin
            fails++; $display("FAIL lu_issue got %0h %0d %0h want 1 7 3000", valid_out, destReg_out, ctrl_out); end
        tests++; if (busA_out !== 32'h11 || busB_out !== 32'h22) begin
            fails++; $display("FAIL lu_ops got %0h %0h want 11 22", busA_out, busB_out); end
        @(negedge clk);
        ex_valid_in = 1'b1;
        ex_destReg_in = 5'd2;
        #1;
        tests++; if (stall_out !== 1'b1) begin fails++; $display("FAIL lu_rs2 got %0h want 1", stall_out); end
        drive(enc_r(5'd0, 5'd2, 5'd7, 6'h20), 32'h0, 32'h22, 32'h204);
        ex_destReg_in = 5'd0;
        #1;
        tests++; if (stall_out !== 1'b0) begin fails++; $display("FAIL lu_r0 got %0h want 0", stall_out); end
        drive(enc_i(6'h08, 5'd1, 5'd3, 16'h0001), 32'h0, 32'h0, 32'h208);
        ex_destReg_in = 5'd3;
        #1;
        tests++; if (stall_out !== 1'b0) begin fails++; $display("FAIL lu_itype_rs2 got %0h want 0", stall_out); end
        edge_settle();
        tests++; if (valid_out !== 1'b1 || destReg_out !== 5'd3) begin
            fails++; $display("FAIL lu_itype_issue got %0h %0d want 1 3", valid_out, destReg_out); end
        drive(enc_i(6'h08, 5'd3, 5'd4, 16'h0001), 32'h0, 32'h0, 32'h20C);
        ex_MemToReg_in = 1'b0;
        #1;
        tests++; if (stall_out !== 1'b0) begin fails++; $display("FAIL lu_not_load got %0h want 0", stall_out); end
        @(negedge clk);
        ex_valid_in = 1'b0;
        ex_destReg_in = 5'd0;
    endtask

    task automatic test_ex_stall;
        drive(enc_i(6'h08, 5'd1, 5'd3, 16'hFFFF), 32'h10, 32'h0, 32'h300);
        edge_settle();
        tests++; if (valid_out !== 1'b1) begin fails++; $display("FAIL hold_base got %0h want 1", valid_out); end
        for (int i = 0; i < 3; i++) begin
            drive(enc_i(6'h0F, 5'd0, 5'd6, 16'h1234), 32'h999, 32'h888, 32'h304);
            ex_stall_in = 1'b1;
            #1;
            tests++; if (stall_out !== 1'b1) begin fails++; $display("FAIL hold_stall[%0d] got %0h want 1", i, stall_out); end
            edge_settle();
            tests++; if (valid_out !== 1'b1 || ctrl_out !== 19'h01080 || destReg_out !== 5'd3) begin
                fails++; $display("FAIL hold_ctrl[%0d] got %0h %0h %0d want 1 1080 3", i, valid_out, ctrl_out, destReg_out); end
            tests++; if (busA_out !== 32'h10 || busB_out !== 32'hFFFFFFFF || nextPC_out !== 32'h300) begin
                fails++; $display("FAIL hold_data[%0d] got %0h %0h %0h want 10 ffffffff 300", i, busA_out, busB_out, nextPC_out); end
        end
        @(negedge clk);
        flush_in = 1'b1;
        #1;
        tests++; if (stall_out !== 1'b0) begin fails++; $display("FAIL flush_stall got %0h want 0", stall_out); end
        edge_settle();
        tests++; if (valid_out !== 1'b0 || ctrl_out !== 19'h0) begin
            fails++; $display("FAIL flush_over_stall got %0h %0h want 0 0", valid_out, ctrl_out); end
        @(negedge clk);
        flush_in = 1'b0;
        ex_stall_in = 1'b0;
    endtask

    task automatic test_link_r0;
        drive({6'h03, 26'h10}, 32'h0, 32'h0, 32'h400);
        edge_settle();
        tests++; if (destReg_out !== 5'd31 || ctrl_out !== 19'h51000) begin
            fails++; $display("FAIL jal got %0d %0h want 31 51000", destReg_out, ctrl_out); end
        drive(enc_i(6'h13, 5'd4, 5'd0, 16'h0), 32'h0, 32'h0, 32'h404);
        edge_settle();
        tests++; if (destReg_out !== 5'd31 || ctrl_out !== 19'h71000) begin
            fails++; $display("FAIL jalr got %0d %0h want 31 71000", destReg_out, ctrl_out); end
        drive(enc_r(5'd1, 5'd2, 5'd0, 6'h20), 32'h0, 32'h0, 32'h408);
        edge_settle();
        tests++; if (destReg_out !== 5'd0 || ctrl_out !== 19'h02000) begin
            fails++; $display("FAIL add_r0 got %0d %0h want 0 2000", destReg_out, ctrl_out); end
        drive(enc_i(6'h08, 5'd1, 5'd0, 16'h5), 32'h0, 32'h0, 32'h40C);
        edge_settle();
        tests++; if (ctrl_out !== 19'h00080 || valid_out !== 1'b1) begin
            fails++; $display("FAIL addi_r0 got %0h %0h want 80 1", ctrl_out, valid_out); end
    endtask

    task automatic test_invalid_flush;
        drive(enc_i(6'h08, 5'd1, 5'd3, 16'h1), 32'h0, 32'h0, 32'h500);
        valid_in = 1'b0;
        edge_settle();
        tests++; if (valid_out !== 1'b0 || ctrl_out !== 19'h0) begin
            fails++; $display("FAIL invalid got %0h %0h want 0 0", valid_out, ctrl_out); end
        drive(enc_i(6'h08, 5'd1, 5'd3, 16'h1), 32'h0, 32'h0, 32'h504);
        flush_in = 1'b1;
        edge_settle();
        tests++; if (valid_out !== 1'b0 || ctrl_out !== 19'h0) begin
            fails++; $display("FAIL flush got %0h %0h want 0 0", valid_out, ctrl_out); end
        @(negedge clk);
        flush_in = 1'b0;
    endtask

    task automatic test_reset_mid;
        drive(enc_i(6'h08, 5'd1, 5'd3, 16'hFFFF), 32'h10, 32'h20, 32'h600);
        edge_settle();
        tests++; if (valid_out !== 1'b1) begin fails++; $display("FAIL mid_pre got %0h want 1", valid_out); end
        #2 reset = 1'b0;
        #1;
        tests++; if (valid_out !== 1'b0 || ctrl_out !== 19'h0 || stall_out !== 1'b0) begin
            fails++; $display("FAIL mid_ctrl got %0h %0h %0h want 0 0 0", valid_out, ctrl_out, stall_out); end
        tests++; if (busA_out !== 32'h0 || busB_out !== 32'h0 || storeData_out !== 32'h0 || nextPC_out !== 32'h0) begin
            fails++; $display("FAIL mid_data got %0h %0h %0h %0h want 0", busA_out, busB_out, storeData_out, nextPC_out); end
        tests++; if (imm16_out !== 16'h0 || imm26_out !== 26'h0 || destReg_out !== 5'h0) begin
            fails++; $display("FAIL mid_imm got %0h %0h %0h want 0", imm16_out, imm26_out, destReg_out); end
        @(negedge clk);
        reset = 1'b1;
    endtask

`ifdef DECODE_WB_BYPASS_EN
    task automatic test_bypass;
        drive(enc_i(6'h08, 5'd4, 5'd1, 16'h0), 32'hBAD, 32'h0, 32'h700);
        wb_RegWrite_in = 1'b1;
        wb_destReg_in = 5'd4;
        wb_data_in = 32'h1234;
        edge_settle();
        tests++; if (busA_out !== 32'h1234) begin fails++; $display("FAIL bypass got %0h want 1234", busA_out); end
        drive(enc_i(6'h08, 5'd0, 5'd1, 16'h0), 32'hBAD, 32'h0, 32'h704);
        wb_destReg_in = 5'd0;
        edge_settle();
        tests++; if (busA_out !== 32'hBAD) begin fails++; $display("FAIL bypass_r0 got %0h want bad", busA_out); end
        @(negedge clk);
        wb_RegWrite_in = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b1;
        valid_in = 1'b0;
        flush_in = 1'b0;
        ex_stall_in = 1'b0;
        ex_valid_in = 1'b0;
        ex_MemToReg_in = 1'b0;
        ex_destReg_in = 5'd0;
        nextPC_in = 32'h0;
        instruction_in = 32'h0;
        busA_in = 32'h0;
        busB_in = 32'h0;
`ifdef DECODE_WB_BYPASS_EN
        wb_RegWrite_in = 1'b0;
        wb_destReg_in = 5'd0;
        wb_data_in = 32'h0;
`endif
        test_reset();
        test_addi();
        test_operands();
        test_load_use();
        test_ex_stall();
        test_link_r0();
        test_invalid_flush();
        test_reset_mid();
`ifdef DECODE_WB_BYPASS_EN
        test_bypass();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/decode_stage_pipelined.md
Name: decode_stage_pipelined

Overview:
- Parametrised successor to the combinational DLX decode stage.
- Decodes the IF/ID instruction, forms ALU operands A/B, immediate fields and the destination register, then registers everything into an ID/EX pipeline register.
- Adds a load-use hazard detector with bubble insertion, a downstream-stall hold, a mispredict flush, and r0-write suppression.
- Sits between the IF/ID register and the execute stage.

Parameters:
- SIZE, 32: datapath / bus width.
- RADDR_W, 5: register-address width.
- LINK_REG, 31: destination for PCtoReg instructions (jal/jalr).
- LHI_SHIFT, 16: constant driven on ALU B for LHI.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- valid_in  in  1  IF/ID slot holds a real instruction.
- nextPC_in  in  SIZE  PC+4 of the instruction.
- instruction_in  in  32  instruction word.
- busA_in  in  SIZE  register-file read port 1 (rs1).
- busB_in  in  SIZE  register-file read port 2 (rs2).
- flush_in  in  1  branch/jump resolved taken; kill the instruction in ID.
- ex_stall_in  in  1  EX cannot accept; hold the ID/EX register.
- ex_valid_in  in  1  EX-stage instruction is valid.
- ex_MemToReg_in  in  1  EX-stage instruction is a load.
- ex_destReg_in  in  RADDR_W  destination of the EX-stage instruction.
- stall_out  out  1  freeze PC and IF/ID (combinational).
- valid_out  out  1  ID/EX slot valid.
- ctrl_out  out  CTRL_W  registered control bundle (layout in package).
- nextPC_out  out  SIZE  registered PC+4.
- busA_out  out  SIZE  registered ALU operand A.
- busB_out  out  SIZE  registered ALU operand B.
- storeData_out  out  SIZE  registered raw busB_in, used for stores.
- imm16_out  out  16  registered instruction[16:31].
- imm26_out  out  26  registered instruction[6:31].
- destReg_out  out  RADDR_W  registered write register.

Behaviour:
- Reset (reset=0, asynchronous): valid_out=0, ctrl_out=0, all data outputs 0. stall_out is combinational and forced 0 while reset is asserted.
- Field extraction: rs1=instr[6:10], rs2=instr[11:15], rd=instr[16:20].
- Destination: rw = RType ? rd : rs2; overridden to LINK_REG when PCtoReg=1.
- Operand B: RType ? busB_in : (LHIOp ? LHI_SHIFT : ext(imm16, extOp)).
  - ext is sign-extend when extOp=1, zero-extend otherwise.
- Operand A: LHIOp ? zero-extended imm16 : busA_in.
- Latency: 1 cycle; all outputs are registered.
- Load-use hazard, asserted when all of the following hold:
  - valid_in, ex_valid_in and ex_MemToReg_in are all 1;
  - ex_destReg_in != 0;
  - ex_destReg_in == rs1, or ex_destReg_in == rs2 with (RType or MemWrite or branch).
- Update priority at each rising edge:
  1. flush_in: load a bubble (valid_out=0, ctrl_out=0). Flush wins even when ex_stall_in=1.
  2. ex_stall_in: hold every output register unchanged.
  3. Hazard: load a bubble.
  4. Otherwise: load the decoded values; valid_out=valid_in.
- stall_out = valid_in & (ex_stall_in | hazard) & ~flush_in.
- valid_in=0 loads a bubble; a bubble never asserts RegWrite or MemWrite.
- r0 write suppression: if the final rw==0, the RegWrite bit of ctrl_out is cleared. Other fields pass through unchanged.
- Back-to-back hazards: the stall lasts exactly one cycle per load. The next cycle the load has left EX, so the dependent instruction proceeds.

Optional Feature:
- Macro DECODE_WB_BYPASS_EN.
- Defined:
  - Adds input ports wb_RegWrite_in (1), wb_destReg_in (RADDR_W) and wb_data_in (SIZE).
  - If wb_RegWrite_in=1, wb_destReg_in!=0 and it matches rs1 (or rs2), wb_data_in replaces busA_in (or busB_in) before operand muxing and before storeData_out.
- Undefined: these ports are absent and register-file values are used as-is. Software or the register file must then provide write-before-read.

Decomposition:
- Package decode_pkg holds:
  - CTRL_W=19 and the bit indices of each control field, in this order: PCtoReg, RegToPC, jump, branch, branchZero, RType, RegWrite, MemToReg, MemWrite, loadSign, mul, extOp, LHIOp, DSize[2], ALUCtrl[4];
  - the bubble constant (all zeros).
- One natural sub-module, decode_hazard_unit: combinational hazard detect plus stall_out generation. It is instantiated alongside the existing control decoder.

Test Plan:
- Reset mid-stream: assert reset=0 while valid_out=1 -> all outputs 0 immediately, with no clock edge needed.
- addi r3,r1,-1 (imm 0xFFFF, extOp=1) -> next cycle busB_out=0xFFFFFFFF, destReg_out=3, valid_out=1.
- lw r5 in EX (ex_MemToReg_in=1, ex_destReg_in=5), ID holds add r7,r5,r2 -> stall_out=1 for 1 cycle, then bubble (valid_out=0). Next cycle with EX clear: add is issued with destReg_out=7.
- ex_stall_in=1 for 3 cycles -> outputs are unchanged across all 3 cycles and stall_out=1. Then flush_in=1 and ex_stall_in=1 together -> valid_out=0 next cycle.
- jal -> destReg_out=31 and RegWrite=1; an add whose rd=0 -> RegWrite bit cleared.
- With DECODE_WB_BYPASS_EN: wb writes r4=0x1234 while ID reads rs1=4 -> busA_out=0x1234.
